// File: rtl/nibble_serial_addsub.sv
// Multi-cycle add/subtract: one 4-bit slice reused WIDTH/4 times, with the carry
// held in a flip-flop between passes. START/DONE handshake to a sequencer.

module addsub_slice4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);
  assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {4'b0, i_ci};
endmodule

module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_y,
  output logic             o_co
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                w_load, w_last;
  logic [N-1:0][3:0]   r_a, r_bx, r_acc, r_y, w_res;
  logic [CW-1:0]       r_cnt;
  logic                r_carry, r_co;
  logic [3:0]          w_s;
  logic                w_c;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // BUSY/DONE decode from the state register only, so no input reaches an output.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_load = 1'b1;
        w_next = S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_load = i_start;
        w_next = i_start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  addsub_slice4 u_slice (
    .i_a  (r_a[r_cnt]),
    .i_b  (r_bx[r_cnt]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_c)
  );

  always_comb begin
    w_res        = r_acc;
    w_res[r_cnt] = w_s;
  end

  // Subtract as A + ~B + 1: invert B and preload the carry with SUB.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a     <= '0;
      r_bx    <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
    end else if (w_load) begin
      r_a     <= i_a;
      r_bx    <= i_b ^ {WIDTH{i_sub}};
      r_carry <= i_sub;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_res;
      r_carry <= w_c;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_y  <= w_res;
        r_co <= w_c;
      end
    end
  end

  assign o_y  = r_y;
  assign o_co = r_co;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed-vector bench for nibble_serial_addsub (WIDTH=16, four passes per op).

module tb_nibble_serial_addsub;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, co;
  logic [15:0] y;

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_addsub #(.WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub),
    .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_y(y), .o_co(co)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch an op in the current cycle (cycle 0); leaves the bench in cycle 1.
  task automatic launch(input logic s, input logic [15:0] va, input logic [15:0] vb);
    sub = s; a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; sub = ~s;
  endtask

  // From cycle 1: check four BUSY cycles with Y held, then the DONE cycle.
  task automatic finish_op(input string tag, input logic [15:0] prev_y,
                           input logic [15:0] ey, input logic ec);
    int nbusy = 0;
    int ndone = 0;
    int nheld = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      if (y === prev_y) nheld++;
      if (i < 3) tick();
    end
    chk({tag, "_busy4"}, nbusy, 4);
    chk({tag, "_nodone_busy"}, ndone, 0);
    chk({tag, "_y_held"}, nheld, 4);
    tick();
    chk({tag, "_done"}, {busy, done}, 2'b01);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_co"}, co, ec);
  endtask

  initial begin
    logic [15:0] ylast;
    #12;
    chk("rst_out", {busy, done, co, y}, 19'h0);
    rst = 1'b0;
    tick();
    chk("idle_out", {busy, done}, 2'b00);

    launch(1'b0, 16'h1234, 16'h0FFF);
    finish_op("add1", 16'h0000, 16'h2233, 1'b0);
    tick();
    chk("add1_done_1cyc", {busy, done}, 2'b00);
    chk("add1_y_hold", y, 16'h2233);

    launch(1'b0, 16'hFFFF, 16'h0001);
    finish_op("add_ripple", 16'h2233, 16'h0000, 1'b1);
    tick();

    launch(1'b1, 16'h0005, 16'h0007);
    finish_op("sub_borrow", 16'h0000, 16'hFFFE, 1'b0);
    tick();

    launch(1'b1, 16'h8000, 16'h8000);
    finish_op("sub_eq", 16'hFFFE, 16'h0000, 1'b1);
    tick();

    launch(1'b1, 16'hA000, 16'h0001);
    finish_op("sub_nb", 16'h0000, 16'h9FFF, 1'b1);
    tick();

    // START with new operands while BUSY must be ignored.
    launch(1'b0, 16'h1111, 16'h2222);
    tick();
    sub = 1'b1; a = 16'hFFFF; b = 16'h0F0F; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy", busy, 1'b1);
    chk("ign_y_held", y, 16'h9FFF);
    tick(); tick();
    chk("ign_done", done, 1'b1);
    chk("ign_y", y, 16'h3333);
    chk("ign_co", co, 1'b0);
    tick();
    chk("ign_idle", {busy, done}, 2'b00);

    // Back-to-back: START held in the DONE cycle.
    launch(1'b0, 16'h1234, 16'h0FFF);
    tick(); tick(); tick(); tick();
    chk("b2b_first_done", done, 1'b1);
    chk("b2b_first_y", y, 16'h2233);
    ylast = y;
    launch(1'b0, 16'h0001, 16'h0001);
    finish_op("b2b_second", ylast, 16'h0002, 1'b0);
    tick();

    // Async reset in the third RUN cycle (pass k=2).
    launch(1'b0, 16'h00FF, 16'h0001);
    tick(); tick();
    chk("rstmid_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_out", {busy, done, co, y}, 19'h0);
    #3 rst = 1'b0;
    begin
      int ndone = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (done || busy) ndone++;
      end
      chk("rstmid_no_done", ndone, 0);
    end

    launch(1'b1, 16'h8000, 16'h8000);
    finish_op("post_rst", 16'h0000, 16'h0000, 1'b1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
